// File: rtl/stack_seq_pkg.sv
// rtl/stack_seq_pkg.sv - shared types and constants for the stack program sequencer
package stack_seq_pkg;

    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] OP_PUSH = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ISSUE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/stack_seq_prog_mem.sv
// rtl/stack_seq_prog_mem.sv - program store, one write port and one combinational read port
module seq_prog_mem #(
    parameter int DW    = 20,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    // Deliberately not reset so a program survives a sequencer reset
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - replays a stored instruction list into an external stack and checks each result
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [W+OP_W-1:0]          prog_data,
    input  logic [$clog2(DEPTH):0]     prog_len,
    input  logic                       start,
    output logic                       stk_rst,
    output logic [OP_W-1:0]            stk_op,
    output logic [W-1:0]               stk_in,
    output logic                       stk_apply,
    input  logic [W-1:0]               stk_head,
    input  logic                       stk_empty,
    input  logic                       stk_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [$clog2(DEPTH)-1:0]   err_pc,
    output logic [W-1:0]               result
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    seq_state_e      state, state_nxt;
    logic [AW-1:0]   pc;
    logic [AW:0]     len_q;
    logic [AW:0]     len_clamped;
    logic [W+OP_W-1:0] instr;
    logic            last;

    seq_prog_mem #(
        .DW    (W + OP_W),
        .DEPTH (DEPTH)
    ) u_prog_mem (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (instr)
    );

    assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign last        = ({1'b0, pc} == (len_q - {{AW{1'b0}}, 1'b1}));

    always_comb begin
        state_nxt = state;
        stk_rst   = !rst_n;
        stk_apply = 1'b0;
        stk_op    = '0;
        stk_in    = '0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                done  = (state == S_DONE);
                error = (state == S_ERR);
                if (start) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                busy      = 1'b1;
                stk_rst   = 1'b1;
                state_nxt = (len_q != '0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                stk_apply = 1'b1;
                stk_op    = instr[W+OP_W-1:W];
                stk_in    = instr[W-1:0];
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (!stk_valid) begin
                    state_nxt = S_ERR;
                end else if (last) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            len_q  <= '0;
            err_pc <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE || state == S_DONE || state == S_ERR) && start) begin
                len_q <= len_clamped;
                pc    <= '0;
            end
            if (state == S_CHECK) begin
                if (!stk_valid) begin
                    err_pc <= pc;
                end else if (!last) begin
                    pc <= pc + 1'b1;
                end
            end
            // A zero-length run leaves CLR with the stack being cleared that same edge
            if ((state == S_CLR || state == S_CHECK) &&
                (state_nxt == S_DONE || state_nxt == S_ERR)) begin
                result <= (state == S_CLR || stk_empty) ? '0 : stk_head;
            end
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// tb/tb_stack_seq.sv - directed bench for stack_seq against a small behavioural stack
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        stk_rst;
    logic [3:0]  stk_op;
    logic [15:0] stk_in;
    logic        stk_apply;
    logic [15:0] stk_head;
    logic        stk_empty;
    logic        stk_valid;
    logic        busy, done, error;
    logic [3:0]  err_pc;
    logic [15:0] result;

    int vectors     = 0;
    int miscompares = 0;
    int fail_at     = 0;
    int cyc;

    always #5 clk = ~clk;

    stack_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .stk_rst   (stk_rst),
        .stk_op    (stk_op),
        .stk_in    (stk_in),
        .stk_apply (stk_apply),
        .stk_head  (stk_head),
        .stk_empty (stk_empty),
        .stk_valid (stk_valid),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_pc    (err_pc),
        .result    (result)
    );

    // Stack model: only push (opcode 7) is legal; fail_at forces the Nth apply invalid
    logic [15:0] smem [16];
    logic [4:0]  sp;
    int          apply_cnt;

    assign stk_empty = (sp == 5'd0);
    assign stk_head  = (sp == 5'd0) ? 16'd0 : smem[sp[3:0] - 4'd1];

    always @(posedge clk) begin
        if (stk_rst) begin
            sp        <= 5'd0;
            stk_valid <= 1'b0;
            apply_cnt <= 0;
        end else if (stk_apply) begin
            apply_cnt <= apply_cnt + 1;
            if ((fail_at != 0 && apply_cnt + 1 == fail_at) || stk_op != 4'd7 || sp == 5'd16) begin
                stk_valid <= 1'b0;
            end else begin
                smem[sp[3:0]] <= stk_in;
                sp            <= sp + 5'd1;
                stk_valid     <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] addr, input logic [3:0] op, input logic [15:0] imm);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = {op, imm};
        tick();
    endtask

    task automatic run_start(input logic [4:0] len);
        prog_len = len;
        start    = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        start     = 1'b0;
        tick();
        tick();
        chk("rst_stk_rst", stk_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_apply", stk_apply, 0);
        chk("rst_result", result, 0);
        chk("rst_err_pc", err_pc, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_stk_rst", stk_rst, 0);

        // single push 5
        load(4'd0, 4'd7, 16'd5);
        run_start(5'd1);
        chk("p1_clr_stk_rst", stk_rst, 1);
        chk("p1_clr_apply", stk_apply, 0);
        chk("p1_clr_busy", busy, 1);
        tick();
        chk("p1_issue_apply", stk_apply, 1);
        chk("p1_issue_op", stk_op, 7);
        chk("p1_issue_in", stk_in, 5);
        tick();
        chk("p1_check_apply", stk_apply, 0);
        chk("p1_check_op", stk_op, 0);
        tick();
        chk("p1_done", done, 1);
        chk("p1_busy", busy, 0);
        chk("p1_error", error, 0);
        chk("p1_result", result, 5);

        // push 1 then illegal op 9
        load(4'd0, 4'd7, 16'd1);
        load(4'd1, 4'd9, 16'd0);
        run_start(5'd2);
        tick();
        tick();
        tick();
        chk("e2_issue_op", stk_op, 9);
        tick();
        tick();
        chk("e2_error", error, 1);
        chk("e2_err_pc", err_pc, 1);
        chk("e2_busy", busy, 0);
        chk("e2_done", done, 0);
        chk("e2_result", result, 1);

        // zero-length run
        run_start(5'd0);
        chk("z_stk_rst", stk_rst, 1);
        chk("z_error_cleared", error, 0);
        tick();
        chk("z_stk_rst_off", stk_rst, 0);
        chk("z_done", done, 1);
        chk("z_result", result, 0);

        // three pushes, start pulsed during CHECK
        load(4'd0, 4'd7, 16'd10);
        load(4'd1, 4'd7, 16'd20);
        load(4'd2, 4'd7, 16'd30);
        run_start(5'd3);
        tick();
        tick();
        start = 1'b1;
        chk("s3_busy_t3", busy, 1);
        tick();
        chk("s3_issue2_in", stk_in, 20);
        tick();
        tick();
        tick();
        chk("s3_busy_t7", busy, 1);
        tick();
        chk("s3_done_t8", done, 1);
        chk("s3_result", result, 30);

        // reset during ISSUE, then rerun from the retained program
        load(4'd0, 4'd7, 16'd5);
        run_start(5'd1);
        tick();
        chk("r_issue_apply", stk_apply, 1);
        rst_n = 1'b0;
        tick();
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        chk("r_error", error, 0);
        chk("r_apply", stk_apply, 0);
        chk("r_op", stk_op, 0);
        chk("r_in", stk_in, 0);
        chk("r_stk_rst", stk_rst, 1);
        chk("r_result", result, 0);
        rst_n = 1'b1;
        tick();
        run_start(5'd1);
        tick();
        tick();
        tick();
        chk("r_rerun_done", done, 1);
        chk("r_rerun_result", result, 5);

        // twelve pushes, stack rejects the twelfth
        for (int i = 0; i < 12; i++) load(4'(i), 4'd7, 16'd1);
        fail_at = 12;
        run_start(5'd12);
        cyc = 1;
        while (!(error || done) && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("f12_cycles", cyc, 26);
        chk("f12_error", error, 1);
        chk("f12_err_pc", err_pc, 11);
        chk("f12_done", done, 0);
        fail_at = 0;

        // length beyond DEPTH is clamped
        for (int i = 0; i < 16; i++) load(4'(i), 4'd7, 16'(100 + i));
        run_start(5'd31);
        cyc = 1;
        while (!(error || done) && cyc < 80) begin
            tick();
            cyc++;
        end
        chk("clamp_cycles", cyc, 34);
        chk("clamp_done", done, 1);
        chk("clamp_result", result, 115);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
